// File: rtl/ec_frontend_pkg.sv
// Shared parameters and state type for the echo-canceller sample front end.
package ec_frontend_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_CNT_W = 13;
    localparam int DEF_LAG_MAX = 16;
    localparam int MIN_SAMPLING_CYCLE = 1200;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } fe_state_t;

    // Lag of 0 means 1 frame; anything past the ring depth saturates.
    function automatic int clamp_lag(input int sel, input int lag_max);
        if (sel == 0) return 1;
        if (sel > lag_max) return lag_max;
        return sel;
    endfunction

endpackage

// File: rtl/lag_ring_ram.sv
// History ring for frame samples: one synchronous write port, one async read port.
module lag_ring_ram #(
    parameter int DEPTH = 16,
    parameter int W = 16,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sample_lag_frontend.sv
// Frame counter plus current/lagged sample pair for the echo canceller.
// Build option UNDERRUN_ZERO_EN: a frame without a new sample pushes 0 instead of repeating.
module sample_lag_frontend
    import ec_frontend_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int LAG_MAX = DEF_LAG_MAX
) (
    input  logic                      clk_operation,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [CNT_W-1:0]          sampling_cycle,
    input  logic [$clog2(LAG_MAX):0]  lag_sel,
    input  logic                      adc_valid,
    input  logic [DATA_W-1:0]         adc_data,
    output logic [CNT_W-1:0]          sampling_cycle_counter,
    output logic [DATA_W-1:0]         sig16b,
    output logic [DATA_W-1:0]         sig16b_lag,
    output logic                      sample_strobe,
    output logic                      lag_valid,
    output logic                      overrun,
    output logic                      underrun,
    output logic                      cfg_err
);

    localparam int PTR_W = $clog2(LAG_MAX);
    localparam int LAG_W = PTR_W + 1;

    fe_state_t         state;
    logic [LAG_W-1:0]  fill_cnt;
    logic [LAG_W-1:0]  lag_q;
    logic [LAG_W-1:0]  lag_eff;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]  sc_eff;
    logic              fresh;
    logic              boundary;
    logic              lag_changed;

    assign cfg_err = sampling_cycle < CNT_W'(MIN_SAMPLING_CYCLE);
    assign sc_eff = (sampling_cycle < CNT_W'(2)) ? CNT_W'(2) : sampling_cycle;

    // >= rather than == so a shrink below the current position closes the frame at once
    assign boundary = enable && (sampling_cycle_counter >= sc_eff - CNT_W'(1));

    assign lag_eff = LAG_W'(clamp_lag(int'(lag_sel), LAG_MAX));
    assign lag_changed = lag_sel != lag_q;
    assign rd_ptr = wr_ptr - lag_eff[PTR_W-1:0];

    always_comb begin
        sample = hold;
        if (adc_valid) begin
            sample = adc_data;
`ifdef UNDERRUN_ZERO_EN
        end else if (!fresh) begin
            sample = '0;
`endif
        end
    end

    lag_ring_ram #(
        .DEPTH(LAG_MAX),
        .W(DATA_W),
        .AW(PTR_W)
    ) u_ring (
        .clk(clk_operation),
        .rst(rst),
        .we(boundary),
        .wr_addr(wr_ptr),
        .wr_data(sample),
        .rd_addr(rd_ptr),
        .rd_data(rd_data)
    );

    always_ff @(posedge clk_operation) begin
        if (rst) begin
            sampling_cycle_counter <= '0;
            sample_strobe <= 1'b0;
            sig16b <= '0;
            hold <= '0;
            fresh <= 1'b0;
            overrun <= 1'b0;
            underrun <= 1'b0;
            wr_ptr <= '0;
            lag_q <= '0;
        end else begin
            lag_q <= lag_sel;
            sample_strobe <= boundary;

            if (!enable || boundary) begin
                sampling_cycle_counter <= '0;
            end else begin
                sampling_cycle_counter <= sampling_cycle_counter + CNT_W'(1);
            end

            if (enable && adc_valid) begin
                hold <= adc_data;
                if (fresh) overrun <= 1'b1;
            end

            if (boundary) begin
                fresh <= 1'b0;
                sig16b <= sample;
                wr_ptr <= wr_ptr + 1'b1;
                if (!fresh && !adc_valid) underrun <= 1'b1;
            end else if (enable && adc_valid) begin
                fresh <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_operation) begin
        if (rst) begin
            state <= IDLE;
            fill_cnt <= '0;
            lag_valid <= 1'b0;
            sig16b_lag <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state <= FILL;
                        fill_cnt <= '0;
                        lag_valid <= 1'b0;
                        sig16b_lag <= '0;
                    end
                end
                FILL: begin
                    if (!enable) begin
                        state <= IDLE;
                        fill_cnt <= '0;
                    end else if (lag_changed) begin
                        fill_cnt <= '0;
                        lag_valid <= 1'b0;
                        sig16b_lag <= '0;
                    end else if (boundary) begin
                        lag_valid <= 1'b0;
                        sig16b_lag <= '0;
                        if (fill_cnt + 1'b1 >= lag_eff) begin
                            state <= RUN;
                            fill_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= IDLE;
                        fill_cnt <= '0;
                    end else if (lag_changed) begin
                        state <= FILL;
                        fill_cnt <= '0;
                        lag_valid <= 1'b0;
                        sig16b_lag <= '0;
                    end else if (boundary) begin
                        lag_valid <= 1'b1;
                        sig16b_lag <= rd_data;
                    end
                end
                default: begin
                    state <= IDLE;
                    fill_cnt <= '0;
                end
            endcase
        end
    end

endmodule
